// File: rtl/up_counter_mod.sv
// Modulo up-counter (0..MAX_COUNT) with clear, load, one-shot halt,
// registered wrap pulse and a saturating wrap-event counter.
module up_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              oneshot,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]  MAX_C    = WIDTH'(MAX_COUNT);
  localparam logic [WRAP_W-1:0] WRAP_SAT = {WRAP_W{1'b1}};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              halted_q, halted_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      count_q      <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      halted_q     <= halted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    halted_d     = halted_q;

    if (clr) begin
      state_d    = RUN;
      count_d    = '0;
      wrap_cnt_d = '0;
      halted_d   = 1'b0;
    end else if (load) begin
      // Out-of-range load values clamp so count never leaves 0..MAX_COUNT.
      count_d  = (load_val > MAX_C) ? MAX_C : load_val;
      state_d  = RUN;
      halted_d = 1'b0;
    end else if (en && (state_q == RUN)) begin
      if (count_q < MAX_C) begin
        count_d = count_q + 1'b1;
      end else if (oneshot) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else begin
        count_d      = '0;
        wrap_pulse_d = 1'b1;
        if (wrap_cnt_q != WRAP_SAT) begin
          wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
      end
    end
  end

  assign count      = count_q;
  assign tc         = (count_q == MAX_C);
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign halted     = halted_q;

endmodule
